neuron_array_core: RTL and testbench
====================================

Name: neuron_array_core

Overview:
- Time-multiplexed FitzHugh-Nagumo neuron array: one shared forward-Euler datapath updates N_NEURONS neurons in round-robin order.
- Each neuron's (v, w) state lives in internal register arrays, in signed fixed point Q(INT_WIDTH).(FRC_WIDTH).
- Input currents arrive on a valid/ready stream. Updated states and spike flags leave on a second valid/ready stream.
- Successor to the single-neuron core. Adds channel count, parametrised shifts and coefficients, saturating arithmetic, spike detection, backpressure and a state-clear command.

Parameters:
- N_NEURONS, 16, neuron count; must be ≥2; index width is clog2(N_NEURONS).
- INT_WIDTH, 3, integer bits of the state format.
- FRC_WIDTH, 12, fraction bits of the state format. W = 1+INT_WIDTH+FRC_WIDTH.
- TAU_SHIFT, 2, log2(tau) applied to the w equation.
- TIME_SHIFT, 7, log2(1/dt).
- A_COEF, 2867, coefficient a in raw W-bit fixed point (≈0.7).
- SPIKE_THRESH, 4096, raw v threshold for spike detection (1.0).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input current valid.
- in_ready, output, 1, core accepts a current.
- in_current, input, W, signed current I for the neuron at the internal pointer.
- clear, input, 1, one-cycle pulse requesting zeroing of all neuron state.
- out_valid, output, 1, update result valid.
- out_ready, input, 1, downstream accepts the result.
- out_idx, output, clog2(N_NEURONS), index of the neuron just updated.
- out_v, output, W, new v.
- out_w, output, W, new w.
- out_spike, output, 1, upward threshold crossing on this update.
- busy, output, 1, FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all v[k]=0, w[k]=0; pointer=0; FSM=IDLE; in_ready=0 during reset, 1 afterwards; out_valid=0; out_idx=0; out_v=0; out_w=0; out_spike=0; busy=0; clear_pending=0.
- FSM states: IDLE, CALC, OUT.
- IDLE: in_ready=1.
  - If clear_pending or clear is high: zero all state, reset pointer=0, clear clear_pending, stay in IDLE. While clear is being applied, in_ready=0.
  - Otherwise, on in_valid&&in_ready: latch v[ptr], w[ptr] and in_current into operand registers, then go to CALC.
- CALC: the combinational step is computed and registered into out_* regs; go to OUT.
- OUT: out_valid=1; all out_* held stable until out_ready. On out_valid&&out_ready:
  - write v[ptr]=out_v, w[ptr]=out_w;
  - ptr = ptr+1, wrapping N_NEURONS-1 → 0;
  - go to IDLE.
- Latency: input handshake in cycle t → out_valid in cycle t+2. Peak throughput is one neuron per 3 cycles.
- Arithmetic (internal width W+4, signed; >>> is arithmetic shift, floor):
  - g = 3*(p2(-v) - p2(v)), where p2 is the shared pow_2_function.
  - z5 = g + 5v - w + I.
  - v_next = sat_W(v + (z5 >>> TIME_SHIFT)).
  - w_next = sat_W(w + ((v + A_COEF - (w >>> 1)) >>> (TAU_SHIFT+TIME_SHIFT))).
  - Both equations use the old v and w.
- Saturation: sat_W clamps to [-2^(W-1), 2^(W-1)-1] and never wraps.
- Spike: out_spike=1 iff old v < SPIKE_THRESH and v_next ≥ SPIKE_THRESH, compared as signed.
- clear arriving while busy sets clear_pending and is applied on the first IDLE cycle after the current OUT handshake. The in-flight result is still delivered and written back before the clear.
- clear and in_valid together in IDLE: clear wins; the input is not accepted (in_ready=0 that cycle).
- rst mid-operation: immediate return to the reset state; the in-flight result is discarded; out_valid drops asynchronously.
- in_current is sampled only at the handshake. Changes while the FSM is in CALC or OUT have no effect.

Decomposition:
- Package neuron_pkg: W-derived widths; the default shift constants; A_COEF and SPIKE_THRESH defaults; the FSM state enum; the sat_W function.
- Sub-module neuron_fhn_step: purely combinational. Inputs v, w, I; outputs v_next, w_next, spike. It instantiates pow_2_function twice, for v and -v.
- neuron_array_core keeps the state arrays, pointer, FSM and handshakes.

Test Plan:
- Release reset, send I=0 to neuron 0 → two cycles after the handshake: out_idx=0, out_v=0, out_w=5 (2867>>>9), out_spike=0.
- N_NEURONS=4, send 5 inputs of I=0 with out_ready=1 → out_idx sequence 0,1,2,3,0. The fifth result has w=10 (built from stored w=5), confirming writeback and wrap.
- Hold out_ready=0 for 5 cycles in OUT → out_* stable, in_ready=0, no state write. Raise out_ready → one handshake, then in_ready=1 the next cycle.
- Repeatedly drive I=16384 (4.0) to one neuron and compare each output against a bit-exact golden model → out_spike=1 exactly on the first update where v crosses 4096, and 0 on the following updates while v stays above the threshold. out_v never wraps sign.
- Pulse clear during CALC → current result is delivered and written. The next IDLE cycle zeroes all state, pointer=0, in_ready=0 for that cycle. The next input to neuron 0 yields v=0, w=5.
- Assert rst during OUT → out_valid=0 immediately, all state reads back 0, pointer=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants, FSM state type and saturation helper for the
// time-multiplexed FitzHugh-Nagumo neuron array.
//
// pow_2_function convention used by this design:
//   p2(x) = max(x, 0)^2 * 2^-P2_SHIFT, in the state fixed-point format, floored.
//   g = 3*(p2(-v) - p2(v)) is therefore the odd, self-limiting term -0.75*v*|v|.
package neuron_pkg;

    localparam int unsigned INT_WIDTH_DEF    = 3;
    localparam int unsigned FRC_WIDTH_DEF    = 12;
    localparam int unsigned W_DEF            = 1 + INT_WIDTH_DEF + FRC_WIDTH_DEF;
    localparam int unsigned TAU_SHIFT_DEF    = 2;
    localparam int unsigned TIME_SHIFT_DEF   = 7;
    localparam int unsigned A_COEF_DEF       = 2867;
    localparam int unsigned SPIKE_THRESH_DEF = 4096;

    // Headroom bits of the internal datapath (internal width is W + EXT_BITS).
    localparam int unsigned EXT_BITS = 4;
    // Extra down-scaling applied inside pow_2_function.
    localparam int unsigned P2_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                                 input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/neuron_fhn_step.sv
// neuron_fhn_step: combinational forward-Euler step of one FitzHugh-Nagumo
// neuron, plus the pow_2_function helper it instantiates twice.
//
// pow_2_function ports:
//   x : signed operand in the internal (W+EXT_BITS) format
//   y : max(x,0)^2 >>> (FRC + SHIFT), same width
// neuron_fhn_step ports:
//   v, w, cur      : old state and input current (W-bit signed)
//   v_next, w_next : saturated new state
//   spike          : upward crossing of SPIKE_THRESH on this step

module pow_2_function #(
    parameter int unsigned XW    = 20,
    parameter int unsigned FRC   = 12,
    parameter int unsigned SHIFT = 2
) (
    input  logic signed [XW-1:0] x,
    output logic signed [XW-1:0] y
);
    localparam int unsigned PW = 2 * XW;

    logic signed [PW-1:0] sq;

    // Half-wave square: negative operands contribute nothing.
    always_comb begin
        sq = PW'(x) * PW'(x);
        y  = '0;
        if (!x[XW-1]) begin
            y = XW'(sq >>> (FRC + SHIFT));
        end
    end
endmodule

module neuron_fhn_step
    import neuron_pkg::*;
#(
    parameter int unsigned W            = W_DEF,
    parameter int unsigned FRC_WIDTH    = FRC_WIDTH_DEF,
    parameter int unsigned TAU_SHIFT    = TAU_SHIFT_DEF,
    parameter int unsigned TIME_SHIFT   = TIME_SHIFT_DEF,
    parameter int unsigned A_COEF       = A_COEF_DEF,
    parameter int unsigned SPIKE_THRESH = SPIKE_THRESH_DEF
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] w,
    input  logic signed [W-1:0] cur,
    output logic signed [W-1:0] v_next,
    output logic signed [W-1:0] w_next,
    output logic                spike
);
    localparam int unsigned XW = W + EXT_BITS;
    localparam logic signed [XW-1:0] A_X   = XW'(A_COEF);
    localparam logic signed [W-1:0]  THR_X = W'(SPIKE_THRESH);

    logic signed [XW-1:0] vx, wx, ix, nvx;
    logic signed [XW-1:0] p2_pos, p2_neg;
    logic signed [XW-1:0] d, g, z5, dw;

    // -v is formed in the wide format so v = -2^(W-1) negates cleanly.
    assign vx  = XW'(v);
    assign wx  = XW'(w);
    assign ix  = XW'(cur);
    assign nvx = -vx;

    pow_2_function #(.XW(XW), .FRC(FRC_WIDTH), .SHIFT(P2_SHIFT)) u_p2_pos (
        .x (vx),
        .y (p2_pos)
    );

    pow_2_function #(.XW(XW), .FRC(FRC_WIDTH), .SHIFT(P2_SHIFT)) u_p2_neg (
        .x (nvx),
        .y (p2_neg)
    );

    // Euler update; both equations read the old v and w.
    always_comb begin
        d      = p2_neg - p2_pos;
        g      = (d <<< 1) + d;
        z5     = g + (vx <<< 2) + vx - wx + ix;
        dw     = vx + A_X - (wx >>> 1);
        v_next = W'(sat_w(64'(vx + (z5 >>> TIME_SHIFT)), W));
        w_next = W'(sat_w(64'(wx + (dw >>> (TAU_SHIFT + TIME_SHIFT))), W));
        spike  = (v < THR_X) && (v_next >= THR_X);
    end
endmodule

// File: rtl/neuron_array_core.sv
// neuron_array_core: round-robin FitzHugh-Nagumo neuron array sharing one
// Euler datapath between N_NEURONS neurons.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : input current stream, in_current for neuron at ptr
//   clear                 : pulse; zeroes all neuron state (deferred while busy)
//   out_valid/out_ready   : result stream carrying out_idx, out_v, out_w, out_spike
//   busy                  : FSM is not idle
module neuron_array_core
    import neuron_pkg::*;
#(
    parameter int unsigned N_NEURONS    = 16,
    parameter int unsigned INT_WIDTH    = INT_WIDTH_DEF,
    parameter int unsigned FRC_WIDTH    = FRC_WIDTH_DEF,
    parameter int unsigned TAU_SHIFT    = TAU_SHIFT_DEF,
    parameter int unsigned TIME_SHIFT   = TIME_SHIFT_DEF,
    parameter int unsigned A_COEF       = A_COEF_DEF,
    parameter int unsigned SPIKE_THRESH = SPIKE_THRESH_DEF,
    localparam int unsigned W           = 1 + INT_WIDTH + FRC_WIDTH,
    localparam int unsigned IW          = $clog2(N_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_current,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IW-1:0]       out_idx,
    output logic signed [W-1:0] out_v,
    output logic signed [W-1:0] out_w,
    output logic                out_spike,
    output logic                busy
);
    state_t state, state_nx;

    logic [IW-1:0]       ptr;
    logic signed [W-1:0] v_mem [N_NEURONS];
    logic signed [W-1:0] w_mem [N_NEURONS];
    logic signed [W-1:0] op_v, op_w, op_i;
    logic signed [W-1:0] step_v, step_w;
    logic                step_spike;
    logic                clear_pending;
    logic                rdy_q;
    logic                do_clear, accept, load_out, out_fire;

    neuron_fhn_step #(
        .W            (W),
        .FRC_WIDTH    (FRC_WIDTH),
        .TAU_SHIFT    (TAU_SHIFT),
        .TIME_SHIFT   (TIME_SHIFT),
        .A_COEF       (A_COEF),
        .SPIKE_THRESH (SPIKE_THRESH)
    ) u_step (
        .v      (op_v),
        .w      (op_w),
        .cur    (op_i),
        .v_next (step_v),
        .w_next (step_w),
        .spike  (step_spike)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake decode; a clear in IDLE blocks acceptance.
    always_comb begin
        state_nx = state;
        do_clear = 1'b0;
        accept   = 1'b0;
        load_out = 1'b0;
        out_fire = 1'b0;
        in_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clear || clear_pending) begin
                    do_clear = 1'b1;
                end else begin
                    in_ready = rdy_q;
                    if (in_valid && rdy_q) begin
                        accept   = 1'b1;
                        state_nx = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                load_out = 1'b1;
                state_nx = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_fire = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);

    // Neuron state, operands, result registers and pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_mem         <= '{default: '0};
            w_mem         <= '{default: '0};
            ptr           <= '0;
            op_v          <= '0;
            op_w          <= '0;
            op_i          <= '0;
            out_idx       <= '0;
            out_v         <= '0;
            out_w         <= '0;
            out_spike     <= 1'b0;
            clear_pending <= 1'b0;
            rdy_q         <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (do_clear) begin
                v_mem         <= '{default: '0};
                w_mem         <= '{default: '0};
                ptr           <= '0;
                clear_pending <= 1'b0;
            end else begin
                // Outside IDLE a clear is remembered until the result retires.
                if (clear) begin
                    clear_pending <= 1'b1;
                end
                if (accept) begin
                    op_v <= v_mem[ptr];
                    op_w <= w_mem[ptr];
                    op_i <= in_current;
                end
                if (load_out) begin
                    out_idx   <= ptr;
                    out_v     <= step_v;
                    out_w     <= step_w;
                    out_spike <= step_spike;
                end
                if (out_fire) begin
                    v_mem[ptr] <= out_v;
                    w_mem[ptr] <= out_w;
                    ptr        <= (ptr == IW'(N_NEURONS - 1)) ? '0 : ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_array_core.sv
// Testbench for neuron_array_core (4 neurons): directed and random transactions
// compared against an integer-arithmetic reference model of the neuron equations.
module tb_neuron_array_core;
    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_current;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_idx;
    logic [15:0] out_v;
    logic [15:0] out_w;
    logic        out_spike;
    logic        busy;

    int     checks = 0;
    int     errors = 0;
    longint mv [N];
    longint mw [N];
    int     mptr;
    int     dut_spk [N];
    int     mod_spk [N];
    longint last_v, last_w;
    int     last_idx;

    neuron_array_core #(.N_NEURONS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_current (in_current),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_v      (out_v),
        .out_w      (out_w),
        .out_spike  (out_spike),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: max(x,0)^2 scaled by 2^-(12+2), floored.
    function automatic longint p2(input longint x);
        return (x > 0) ? (x * x) / 16384 : 0;
    endfunction

    function automatic longint sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model_step(input longint v, input longint w, input longint i,
                                       output longint nv, output longint nw, output bit sp);
        longint g, z5;
        g  = 3 * (p2(-v) - p2(v));
        z5 = g + 5 * v - w + i;
        nv = sat16(v + (z5 >>> 7));
        nw = sat16(w + ((v + 2867 - (w >>> 1)) >>> 9));
        sp = (v < 4096) && (nv >= 4096);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N; k++) begin
            mv[k] = 0;
            mw[k] = 0;
        end
        mptr = 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_v", $signed(out_v), 0);
        chk("rst_out_w", $signed(out_w), 0);
        chk("rst_out_spike", out_spike, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One full transaction: handshake, latency, result, optional backpressure
    // and optional clear pulse during CALC.
    task automatic transact(input logic [15:0] cur, input int hold, input bit clr);
        longint ev, ew;
        bit     es;
        int     n, idx;
        @(negedge clk);
        in_valid = 1'b1; in_current = cur; #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("in_ready_wait", in_ready, 1);
        if (in_ready !== 1'b1) begin
            in_valid = 1'b0;
            return;
        end
        idx = mptr;
        model_step(mv[idx], mw[idx], longint'($signed(cur)), ev, ew, es);
        @(negedge clk);
        in_valid = 1'b0; in_current = 16'($urandom); clear = clr; #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        clear = 1'b0; in_current = 16'($urandom); #1;
        chk("t2_out_valid", out_valid, 1);
        chk("out_idx", out_idx, idx);
        chk("out_v", $signed(out_v), ev);
        chk("out_w", $signed(out_w), ew);
        chk("out_spike", out_spike, es);
        last_v = $signed(out_v); last_w = $signed(out_w); last_idx = int'(out_idx);
        dut_spk[idx] += int'(out_spike);
        mod_spk[idx] += int'(es);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_v", $signed(out_v), ev);
            chk("hold_out_w", $signed(out_w), ew);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0; #1;
        mv[idx] = ev; mw[idx] = ew; mptr = (mptr + 1) % N;
        chk("post_out_valid", out_valid, 0);
        if (clr) begin
            chk("clear_in_ready_low", in_ready, 0);
            model_clear();
            @(negedge clk); #1;
        end
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_current = '0; clear = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            dut_spk[k] = 0;
            mod_spk[k] = 0;
        end
        do_reset();
        @(negedge clk); #1;
        chk("ready_after_reset", in_ready, 1);

        // First update of neuron 0, then wrap and writeback.
        transact(16'd0, 0, 1'b0);
        chk("first_w", last_w, 5);
        repeat (4) transact(16'd0, 0, 1'b0);
        chk("wrap_idx", last_idx, 0);
        chk("wrap_w", last_w, 10);

        // Backpressure for 5 cycles.
        transact(16'd0, 5, 1'b0);

        // Random currents and random backpressure.
        for (int r = 0; r < 40; r++) begin
            transact(16'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // Clear pulse during CALC: result retires, then state is zeroed.
        transact(16'($urandom), 1, 1'b1);
        transact(16'd0, 0, 1'b0);
        chk("after_clear_idx", last_idx, 0);
        chk("after_clear_v", last_v, 0);
        chk("after_clear_w", last_w, 5);

        // Clear together with in_valid in IDLE: clear wins.
        @(negedge clk);
        in_valid = 1'b1; clear = 1'b1; in_current = 16'd1234; #1;
        chk("clear_vs_valid_in_ready", in_ready, 0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; #1;
        chk("clear_vs_valid_busy", busy, 0);
        chk("clear_vs_valid_ready", in_ready, 1);
        model_clear();

        // Sustained drive: neuron 0 at 4.0, others at extremes.
        for (int k = 0; k < N; k++) begin
            dut_spk[k] = 0;
            mod_spk[k] = 0;
        end
        for (int r = 0; r < 150; r++) begin
            transact(16'd16384, int'($urandom_range(0, 1)), 1'b0);
            transact(16'h7fff, 0, 1'b0);
            transact(16'h8000, 0, 1'b0);
            transact(16'($urandom), 0, 1'b0);
        end
        chk("spike_count_n0", dut_spk[0], mod_spk[0]);
        chk("spike_seen_n0", dut_spk[0] >= 1, 1);

        // Reset while a result is waiting in OUT.
        @(negedge clk);
        in_valid = 1'b1; in_current = 16'd100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1; #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        do_reset();
        for (int k = 0; k < N; k++) begin
            transact(16'd0, 0, 1'b0);
            chk("post_rst_idx", last_idx, k);
            chk("post_rst_w", last_w, 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
